// File: rtl/counter_delay_sequencer.sv
// Round-robin Avalon master that time-shares one Counter as a delay timer.
// Define COUNTER_SEQ_TIMEOUT_EN to bound polling and flag timeouts on o_Err.
module counter_delay_sequencer #(
  parameter int unsigned p_NUM_REQ        = 4,
  parameter logic [29:0] p_CNT_BASE       = '0,
  parameter logic [31:0] p_MIN_TRIG       = 32'd16,
  parameter int unsigned p_TIMEOUT_MARGIN = 64
) (
  input  logic                   i_Clk,
  input  logic                   i_Rst,
  input  logic [p_NUM_REQ-1:0]   i_Req,
  input  logic [32*p_NUM_REQ-1:0] i_Delay,
  output logic [p_NUM_REQ-1:0]   o_Ack,
  output logic                   o_Err,
  output logic                   o_Busy,
  output logic [29:0]            o_AV_Address,
  output logic [3:0]             o_AV_ByteEn,
  output logic                   o_AV_Read,
  output logic                   o_AV_Write,
  output logic [31:0]            o_AV_WriteData,
  input  logic [31:0]            i_AV_ReadData,
  input  logic                   i_AV_WaitRequest
);

  localparam int IW = $clog2(p_NUM_REQ);
  localparam logic [29:0] CTRL_A = p_CNT_BASE;
  localparam logic [29:0] TRIG_A = p_CNT_BASE + 30'd1;

  typedef enum logic [3:0] {
    S_INIT, S_IDLE, S_WR_TRIG, S_WR_CTRL, S_SETTLE,
    S_RD_REQ, S_RD_WAIT, S_WR_STOP, S_ACK
  } state_t;

  state_t      state;
  logic [IW-1:0] ptr, gnt, sel;
  logic        sel_vld;
  logic [31:0] trig, sel_dly, sel_trig;
  logic        settle;
  logic        tmo;
  logic [31:0] dly [p_NUM_REQ];

  for (genvar k = 0; k < p_NUM_REQ; k++) begin : g_dly
    assign dly[k] = i_Delay[32*k +: 32];
  end

  // Lowest offset from the pointer wins, so scan from the far end.
  always_comb begin
    int j;
    j       = 0;
    sel     = '0;
    sel_vld = 1'b0;
    for (int i = int'(p_NUM_REQ) - 1; i >= 0; i--) begin
      j = int'(ptr) + i;
      if (j >= int'(p_NUM_REQ)) j = j - int'(p_NUM_REQ);
      if (i_Req[IW'(j)]) begin
        sel     = IW'(j);
        sel_vld = 1'b1;
      end
    end
  end

  assign sel_dly  = dly[sel];
  assign sel_trig = (sel_dly < p_MIN_TRIG) ? p_MIN_TRIG : sel_dly;

  logic unused_rd;
  assign unused_rd = ^{i_AV_ReadData[31:2], i_AV_ReadData[0]};

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state          <= S_INIT;
      ptr            <= '0;
      gnt            <= '0;
      trig           <= '0;
      settle         <= 1'b0;
      o_Ack          <= '0;
      o_Busy         <= 1'b0;
      o_AV_Address   <= '0;
      o_AV_ByteEn    <= '0;
      o_AV_Read      <= 1'b0;
      o_AV_Write     <= 1'b0;
      o_AV_WriteData <= '0;
    end else begin
      o_Ack <= '0;
      unique case (state)
        S_INIT: begin
          if (!o_AV_Write) begin
            o_Busy         <= 1'b1;
            o_AV_Write     <= 1'b1;
            o_AV_ByteEn    <= 4'hF;
            o_AV_Address   <= CTRL_A;
            o_AV_WriteData <= '0;
          end else if (!i_AV_WaitRequest) begin
            o_Busy      <= 1'b0;
            o_AV_Write  <= 1'b0;
            o_AV_ByteEn <= '0;
            state       <= S_IDLE;
          end
        end
        S_IDLE: begin
          if (sel_vld) begin
            gnt            <= sel;
            ptr            <= (sel == IW'(p_NUM_REQ - 1)) ? '0 : sel + 1'b1;
            trig           <= sel_trig;
            o_Busy         <= 1'b1;
            o_AV_Write     <= 1'b1;
            o_AV_ByteEn    <= 4'hF;
            o_AV_Address   <= TRIG_A;
            o_AV_WriteData <= sel_trig;
            state          <= S_WR_TRIG;
          end
        end
        S_WR_TRIG: begin
          if (!i_AV_WaitRequest) begin
            o_AV_Address   <= CTRL_A;
            o_AV_WriteData <= 32'h3;
            state          <= S_WR_CTRL;
          end
        end
        S_WR_CTRL: begin
          if (!i_AV_WaitRequest) begin
            o_AV_Write  <= 1'b0;
            o_AV_ByteEn <= '0;
            settle      <= 1'b0;
            state       <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          settle <= 1'b1;
          if (settle) begin
            o_AV_Read    <= 1'b1;
            o_AV_ByteEn  <= 4'hF;
            o_AV_Address <= CTRL_A;
            state        <= S_RD_REQ;
          end
        end
        S_RD_REQ: begin
          if (!i_AV_WaitRequest) begin
            o_AV_Read   <= 1'b0;
            o_AV_ByteEn <= '0;
            state       <= S_RD_WAIT;
          end
        end
        S_RD_WAIT: begin
          o_AV_ByteEn  <= 4'hF;
          o_AV_Address <= CTRL_A;
          if (i_AV_ReadData[1] || tmo) begin
            o_AV_Write     <= 1'b1;
            o_AV_WriteData <= '0;
            state          <= S_WR_STOP;
          end else begin
            o_AV_Read <= 1'b1;
            state     <= S_RD_REQ;
          end
        end
        S_WR_STOP: begin
          if (!i_AV_WaitRequest) begin
            o_AV_Write  <= 1'b0;
            o_AV_ByteEn <= '0;
            o_Ack[gnt]  <= 1'b1;
            state       <= S_ACK;
          end
        end
        S_ACK: begin
          o_Busy <= 1'b0;
          state  <= S_IDLE;
        end
        default: state <= S_INIT;
      endcase
    end
  end

`ifdef COUNTER_SEQ_TIMEOUT_EN
  logic [32:0] poll_cnt;
  logic        err_q;

  assign tmo = poll_cnt > ({1'b0, trig} + 33'(p_TIMEOUT_MARGIN));

  // Poll counter is zero on the first WR_CTRL cycle and saturates.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      poll_cnt <= '0;
      err_q    <= 1'b0;
      o_Err    <= 1'b0;
    end else begin
      o_Err <= 1'b0;
      if (state == S_WR_TRIG) poll_cnt <= '0;
      else if (poll_cnt != '1) poll_cnt <= poll_cnt + 1'b1;
      if (state == S_RD_WAIT && !i_AV_ReadData[1] && tmo) err_q <= 1'b1;
      if (state == S_WR_STOP && !i_AV_WaitRequest) begin
        o_Err <= err_q;
        err_q <= 1'b0;
      end
    end
  end
`else
  assign tmo   = 1'b0;
  assign o_Err = 1'b0;
  logic unused_cfg;
  assign unused_cfg = ^{p_TIMEOUT_MARGIN, trig};
`endif

endmodule

// File: tb/tb_counter_delay_sequencer.sv
// Directed bench for counter_delay_sequencer with a behavioural Counter slave.
// Timeout phase runs only when COUNTER_SEQ_TIMEOUT_EN is defined.
module tb_counter_delay_sequencer;

  localparam logic [29:0] CTRL_A = 30'd0;
  localparam logic [29:0] TRIG_A = 30'd1;

  logic         i_Clk = 1'b0;
  logic         i_Rst;
  logic [3:0]   i_Req;
  logic [127:0] i_Delay;
  logic [3:0]   o_Ack;
  logic         o_Err, o_Busy;
  logic [29:0]  o_AV_Address;
  logic [3:0]   o_AV_ByteEn;
  logic         o_AV_Read, o_AV_Write;
  logic [31:0]  o_AV_WriteData;
  logic [31:0]  rdata = '0;
  logic         wreq;

  counter_delay_sequencer dut (
    .i_Clk(i_Clk), .i_Rst(i_Rst), .i_Req(i_Req), .i_Delay(i_Delay),
    .o_Ack(o_Ack), .o_Err(o_Err), .o_Busy(o_Busy),
    .o_AV_Address(o_AV_Address), .o_AV_ByteEn(o_AV_ByteEn),
    .o_AV_Read(o_AV_Read), .o_AV_Write(o_AV_Write),
    .o_AV_WriteData(o_AV_WriteData), .i_AV_ReadData(rdata),
    .i_AV_WaitRequest(wreq)
  );

  always #5 i_Clk = ~i_Clk;

  // Counter slave model
  logic [31:0] m_trig = '0, m_cnt = '0;
  logic        m_en = 1'b0, m_ovf = 1'b0;
  logic        stall_on = 1'b0, never_ovf = 1'b0;
  int          scnt = 0;
  int          cyc = 0;

  assign wreq = (o_AV_Read || o_AV_Write) && stall_on && (scnt < 3);

  always @(posedge i_Clk) begin
    cyc <= cyc + 1;
    if (m_en) begin
      if (m_cnt + 32'd1 >= m_trig) begin
        m_cnt <= '0;
        if (!never_ovf) m_ovf <= 1'b1;
      end else m_cnt <= m_cnt + 32'd1;
    end
    if (o_AV_Write && !wreq) begin
      if (o_AV_Address == CTRL_A) begin
        m_en <= o_AV_WriteData[0];
        if (o_AV_WriteData[1]) m_ovf <= 1'b0;
      end else if (o_AV_Address == TRIG_A) m_trig <= o_AV_WriteData;
    end
    if (o_AV_Read && !wreq) rdata <= {30'd0, m_ovf, m_en};
    if (wreq) scnt <= scnt + 1;
    else scnt <= 0;
  end

  // Bus monitor
  typedef struct { int cyc; logic [29:0] a; logic [31:0] d; } wr_t;
  typedef struct { int cyc; logic [3:0] v; logic e; } ack_t;
  wr_t  wq[$];
  ack_t aq[$];
  logic both = 1'b0, be_bad = 1'b0, err_seen = 1'b0, stalled = 1'b0;
  logic pw, pr;
  logic [29:0] pa;
  logic [31:0] pd;
  int stab_bad = 0;

  always @(negedge i_Clk) begin
    if (o_AV_Write && !wreq) wq.push_back('{cyc, o_AV_Address, o_AV_WriteData});
    if (|o_Ack) aq.push_back('{cyc, o_Ack, o_Err});
    if (o_AV_Read && o_AV_Write) both <= 1'b1;
    if (o_Err) err_seen <= 1'b1;
    if (o_AV_ByteEn !== ((o_AV_Read || o_AV_Write) ? 4'hF : 4'h0)) be_bad <= 1'b1;
    if (stalled && (o_AV_Write !== pw || o_AV_Read !== pr ||
                    o_AV_Address !== pa || o_AV_WriteData !== pd))
      stab_bad <= stab_bad + 1;
    stalled <= wreq;
    pw <= o_AV_Write;
    pr <= o_AV_Read;
    pa <= o_AV_Address;
    pd <= o_AV_WriteData;
  end

  int checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_rng(input string tag, input int v, input int lo, input int hi);
    checks++;
    assert (v >= lo && v <= hi) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d..%0d", tag, v, lo, hi);
    end
  endtask

  task automatic wait_acks(input int n, input int budget, input string tag);
    int c = 0;
    while (aq.size() < n && c < budget) begin
      @(posedge i_Clk); #2;
      c++;
    end
    chk({tag, "_done"}, 64'(aq.size() >= n), 64'd1);
  endtask

  task automatic wait_writes(input int n, input int budget, input string tag);
    int c = 0;
    while (wq.size() < n && c < budget) begin
      @(posedge i_Clk); #2;
      c++;
    end
    chk({tag, "_done"}, 64'(wq.size() >= n), 64'd1);
  endtask

  task automatic run_job(input int k, input logic [31:0] d, input logic [31:0] t,
                         input int lo, input int hi, input logic e, input string tag);
    wq.delete();
    aq.delete();
    i_Delay[32*k +: 32] = d;
    i_Req[k] = 1'b1;
    wait_acks(1, 3000, tag);
    i_Req[k] = 1'b0;
    repeat (5) @(posedge i_Clk);
    #2;
    chk({tag, "_nwr"}, 64'(wq.size()), 64'd3);
    chk({tag, "_nack"}, 64'(aq.size()), 64'd1);
    if (wq.size() == 3 && aq.size() == 1) begin
      chk({tag, "_trig_a"}, 64'(wq[0].a), 64'(TRIG_A));
      chk({tag, "_trig_d"}, 64'(wq[0].d), 64'(t));
      chk({tag, "_en_a"}, 64'(wq[1].a), 64'(CTRL_A));
      chk({tag, "_en_d"}, 64'(wq[1].d), 64'h3);
      chk({tag, "_stop_a"}, 64'(wq[2].a), 64'(CTRL_A));
      chk({tag, "_stop_d"}, 64'(wq[2].d), 64'h0);
      chk({tag, "_stop_ord"}, 64'(wq[2].cyc < aq[0].cyc), 64'd1);
      chk({tag, "_ackv"}, 64'(aq[0].v), 64'(4'b0001 << k));
      chk({tag, "_err"}, 64'(aq[0].e), 64'(e));
      chk_rng({tag, "_lat"}, aq[0].cyc - (wq[0].cyc - 1), lo, hi);
    end
  endtask

  initial begin
    i_Rst   = 1'b1;
    i_Req   = '0;
    i_Delay = '0;
    repeat (2) @(posedge i_Clk);
    #2;
    chk("rst_write", 64'(o_AV_Write), 64'd0);
    chk("rst_read", 64'(o_AV_Read), 64'd0);
    chk("rst_busy", 64'(o_Busy), 64'd0);
    chk("rst_ack", 64'(o_Ack), 64'd0);
    chk("rst_addr", 64'(o_AV_Address), 64'd0);
    chk("rst_be", 64'(o_AV_ByteEn), 64'd0);
    i_Rst = 1'b0;
    wait_writes(1, 50, "init");
    chk("init_addr", 64'(wq[0].a), 64'(CTRL_A));
    chk("init_data", 64'(wq[0].d), 64'd0);
    chk("init_busy", 64'(o_Busy), 64'd0);

    run_job(1, 32'd100, 32'd100, 101, 114, 1'b0, "job1");
    run_job(0, 32'd0, 32'd16, 5, 30, 1'b0, "clamp0");
    run_job(2, 32'd16, 32'd16, 5, 30, 1'b0, "clamp16");

    // Contention from reset: 0, 2, 3 held continuously
    i_Rst   = 1'b1;
    i_Delay = {4{32'd20}};
    i_Req   = 4'b1101;
    repeat (2) @(posedge i_Clk);
    #2;
    wq.delete();
    aq.delete();
    i_Rst = 1'b0;
    wait_acks(4, 600, "rr");
    chk("rr0", 64'(aq[0].v), 64'b0001);
    chk("rr1", 64'(aq[1].v), 64'b0100);
    chk("rr2", 64'(aq[2].v), 64'b1000);
    chk("rr3", 64'(aq[3].v), 64'b0001);
    for (int i = 0; i < 3; i++)
      chk_rng("rr_gap", aq[i+1].cyc - aq[i].cyc, 2, 100);

    // Reset while the next job is writing CTRL
    repeat (2) @(posedge i_Clk);
    #2;
    chk("mid_busy_pre", 64'(o_Busy), 64'd1);
    chk("mid_wr_pre", 64'(o_AV_Write), 64'd1);
    i_Rst = 1'b1;
    #1;
    chk("mid_wr", 64'(o_AV_Write), 64'd0);
    chk("mid_rd", 64'(o_AV_Read), 64'd0);
    chk("mid_busy", 64'(o_Busy), 64'd0);
    i_Req = '0;
    repeat (2) @(posedge i_Clk);
    #2;
    wq.delete();
    i_Rst = 1'b0;
    wait_writes(1, 50, "reinit");
    chk("reinit_d", 64'(wq[0].d), 64'd0);
    chk("mid_noack", 64'(aq.size()), 64'd4);

    stall_on = 1'b1;
    run_job(1, 32'd30, 32'd30, 5, 400, 1'b0, "stall");
    chk("stall_stable", 64'(stab_bad), 64'd0);
    stall_on = 1'b0;

`ifdef COUNTER_SEQ_TIMEOUT_EN
    never_ovf = 1'b1;
    run_job(3, 32'd20, 32'd20, 85, 300, 1'b1, "tmo");
    never_ovf = 1'b0;
`else
    chk("err_tied", 64'(err_seen), 64'd0);
`endif

    chk("never_both", 64'(both), 64'd0);
    chk("byteen", 64'(be_bad), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
